// File: rtl/ttt_move_gen_pkg.sv
// Shared types, the line/cell index table and small index helpers for the
// tic-tac-toe automatic move generator.
`default_nettype none

package ttt_move_gen_pkg;

  typedef enum logic [1:0] {
    CELL_P0    = 2'd0,
    CELL_P1    = 2'd1,
    CELL_EMPTY = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINES = 2'd1,
    ST_CELLS = 2'd2,
    ST_ISSUE = 2'd3
  } fsm_t;

  // Board as 9 cells, cell index = 3*x + y, matching the flat 18-bit layout.
  typedef logic [8:0][1:0] board_t;

  localparam logic [2:0] LAST_LINE  = 3'd7;
  localparam logic [3:0] LAST_CELL  = 4'd8;
  localparam logic [3:0] CENTRE_IDX = 4'd4;

  // Rows 0-2, columns 0-2, main diagonal, anti-diagonal.
  localparam logic [3:0] LINE_CELLS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] pos);
    line_cell = LINE_CELLS[line][pos];
  endfunction

  function automatic logic [1:0] idx_x(input logic [3:0] idx);
    if (idx < 4'd3)      idx_x = 2'd0;
    else if (idx < 4'd6) idx_x = 2'd1;
    else                 idx_x = 2'd2;
  endfunction

  function automatic logic [1:0] idx_y(input logic [3:0] idx);
    idx_y = 2'(idx - 4'd3 * {2'b00, idx_x(idx)});
  endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_move_gen_if.sv
// Move handshake between the move generator (master) and the game core (slave).
`default_nettype none

interface ttt_move_gen_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_x;
  logic [1:0] move_y;
  logic [1:0] move_player;

  modport master (
    output move_valid,
    output move_x,
    output move_y,
    output move_player,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_x,
    input  move_y,
    input  move_player,
    output move_ready
  );
endinterface

`default_nettype wire

// File: rtl/ttt_move_gen_line_eval.sv
// Combinational evaluation of one 3-cell line: two of mine plus one empty is a
// win, two of the opponent plus one empty is a block.
`default_nettype none

module ttt_line_eval #(
  parameter logic [1:0] EMPTY_CODE = 2'd3
) (
  input  logic [2:0][1:0] cells,
  input  logic            my_player,
  output logic            is_win,
  output logic            is_block,
  output logic [1:0]      empty_pos
);

  logic [1:0] mine;
  logic [1:0] opp;
  logic [1:0] n_mine;
  logic [1:0] n_opp;
  logic [1:0] n_empty;

  // Code 2 matches none of the three comparisons, so it counts as nothing.
  always_comb begin
    mine      = {1'b0, my_player};
    opp       = {1'b0, ~my_player};
    n_mine    = 2'd0;
    n_opp     = 2'd0;
    n_empty   = 2'd0;
    empty_pos = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (cells[i] == mine) n_mine = n_mine + 2'd1;
      if (cells[i] == opp)  n_opp  = n_opp + 2'd1;
      if (cells[i] == EMPTY_CODE) begin
        n_empty   = n_empty + 2'd1;
        empty_pos = 2'(i);
      end
    end
  end

  assign is_win   = (n_mine == 2'd2) && (n_empty == 2'd1);
  assign is_block = (n_opp == 2'd2) && (n_empty == 2'd1);

endmodule

`default_nettype wire

// File: rtl/ttt_move_gen.sv
// Automatic opponent: snapshots the board on start, scans win > block > centre >
// first empty cell, and offers the chosen move on a valid/ready handshake.
`default_nettype none

module ttt_move_gen
  import ttt_move_gen_pkg::*;
#(
  parameter logic [1:0] EMPTY_CODE = 2'd3,
  parameter bit         USE_BLOCK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  my_player,
  input  logic [17:0]           board_in,
  input  logic                  stop_game,
  output logic                  busy,
  output logic                  no_move,
  ttt_move_gen_if.master        mv
);

  fsm_t       state_q, state_d;
  board_t     board_q, board_d;
  logic       player_q, player_d;
  logic [2:0] line_cnt_q, line_cnt_d;
  logic [3:0] cell_cnt_q, cell_cnt_d;
  logic       blk_found_q, blk_found_d;
  logic [3:0] blk_idx_q, blk_idx_d;
  logic       valid_q, valid_d;
  logic [1:0] x_q, x_d;
  logic [1:0] y_q, y_d;
  logic [1:0] mplayer_q, mplayer_d;
  logic       busy_q, busy_d;
  logic       no_move_q, no_move_d;

  logic [2:0][1:0] line_cells;
  logic            is_win;
  logic            is_block;
  logic [1:0]      empty_pos;
  logic [3:0]      line_idx;
  logic            blk_hit;
  logic            issue;
  logic [3:0]      issue_idx;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      line_cells[p] = board_q[LINE_CELLS[line_cnt_q][p]];
    end
  end

  ttt_line_eval #(
    .EMPTY_CODE (EMPTY_CODE)
  ) u_line_eval (
    .cells     (line_cells),
    .my_player (player_q),
    .is_win    (is_win),
    .is_block  (is_block),
    .empty_pos (empty_pos)
  );

  assign line_idx = line_cell(line_cnt_q, empty_pos);
  assign blk_hit  = (USE_BLOCK != 1'b0) && is_block;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    player_d    = player_q;
    line_cnt_d  = line_cnt_q;
    cell_cnt_d  = cell_cnt_q;
    blk_found_d = blk_found_q;
    blk_idx_d   = blk_idx_q;
    valid_d     = valid_q;
    x_d         = x_q;
    y_d         = y_q;
    mplayer_d   = mplayer_q;
    busy_d      = busy_q;
    no_move_d   = 1'b0;
    issue       = 1'b0;
    issue_idx   = CENTRE_IDX;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop_game) begin
          board_d     = board_t'(board_in);
          player_d    = my_player;
          busy_d      = 1'b1;
          line_cnt_d  = 3'd0;
          blk_found_d = 1'b0;
          state_d     = ST_LINES;
        end
      end

      ST_LINES: begin
        if (is_win) begin
          issue     = 1'b1;
          issue_idx = line_idx;
        end else begin
          // Only the first block in line order is remembered.
          if (blk_hit && !blk_found_q) begin
            blk_found_d = 1'b1;
            blk_idx_d   = line_idx;
          end
          if (line_cnt_q == LAST_LINE) begin
            if (blk_found_q) begin
              issue     = 1'b1;
              issue_idx = blk_idx_q;
            end else if (blk_hit) begin
              issue     = 1'b1;
              issue_idx = line_idx;
            end else if (board_q[CENTRE_IDX] == EMPTY_CODE) begin
              issue     = 1'b1;
              issue_idx = CENTRE_IDX;
            end else begin
              cell_cnt_d = 4'd0;
              state_d    = ST_CELLS;
            end
          end else begin
            line_cnt_d = line_cnt_q + 3'd1;
          end
        end
      end

      ST_CELLS: begin
        if (board_q[cell_cnt_q] == EMPTY_CODE) begin
          issue     = 1'b1;
          issue_idx = cell_cnt_q;
        end else if (cell_cnt_q == LAST_CELL) begin
          no_move_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cell_cnt_d = cell_cnt_q + 4'd1;
        end
      end

      ST_ISSUE: begin
        if (mv.move_ready) begin
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          x_d       = 2'd0;
          y_d       = 2'd0;
          mplayer_d = 2'd0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      valid_d   = 1'b1;
      x_d       = idx_x(issue_idx);
      y_d       = idx_y(issue_idx);
      mplayer_d = {1'b0, player_q};
      state_d   = ST_ISSUE;
    end

    // Game over wins over everything, including a same-cycle accept.
    if (stop_game) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      no_move_d = 1'b0;
      x_d       = 2'd0;
      y_d       = 2'd0;
      mplayer_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      board_q     <= {9{EMPTY_CODE}};
      player_q    <= 1'b0;
      line_cnt_q  <= 3'd0;
      cell_cnt_q  <= 4'd0;
      blk_found_q <= 1'b0;
      blk_idx_q   <= 4'd0;
      valid_q     <= 1'b0;
      x_q         <= 2'd0;
      y_q         <= 2'd0;
      mplayer_q   <= 2'd0;
      busy_q      <= 1'b0;
      no_move_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      player_q    <= player_d;
      line_cnt_q  <= line_cnt_d;
      cell_cnt_q  <= cell_cnt_d;
      blk_found_q <= blk_found_d;
      blk_idx_q   <= blk_idx_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mplayer_q   <= mplayer_d;
      busy_q      <= busy_d;
      no_move_q   <= no_move_d;
    end
  end

  assign mv.move_valid  = valid_q;
  assign mv.move_x      = x_q;
  assign mv.move_y      = y_q;
  assign mv.move_player = mplayer_q;
  assign busy           = busy_q;
  assign no_move        = no_move_q;

endmodule

`default_nettype wire

// File: tb/tb_ttt_move_gen.sv
// Directed self-checking bench for ttt_move_gen.
`default_nettype none

module tb_ttt_move_gen;

  localparam logic [1:0] E = 2'd3;
  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] B = 2'd1;
  localparam logic [1:0] N = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        my_player = 1'b0;
  logic        stop_game = 1'b0;
  logic [17:0] board_in = '1;
  logic        busy;
  logic        no_move;

  int checks = 0;
  int errors = 0;

  ttt_move_gen_if mv_if();

  ttt_move_gen #(
    .EMPTY_CODE (2'd3),
    .USE_BLOCK  (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .my_player (my_player),
    .board_in  (board_in),
    .stop_game (stop_game),
    .busy      (busy),
    .no_move   (no_move),
    .mv        (mv_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [17:0] brd(input logic [1:0] c00, c01, c02,
                                      c10, c11, c12, c20, c21, c22);
    return {c22, c21, c20, c12, c11, c10, c02, c01, c00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle of the start strobe counts as 0; the cycle after it as 1.
  task automatic launch(input logic [17:0] b, input logic p);
    board_in  = b;
    my_player = p;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_valid(input int first, output int n);
    n = first;
    while (mv_if.move_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic accept(input string tag);
    mv_if.move_ready = 1'b1;
    tick();
    mv_if.move_ready = 1'b0;
    chk({tag, "_valid_after_accept"}, 32'(mv_if.move_valid), 32'd0);
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int first_nm;
    bit saw_valid;
    logic [1:0] sx;
    logic [1:0] sy;

    mv_if.move_ready = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 32'(mv_if.move_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_no_move", 32'(no_move), 32'd0);
    chk("reset_xy_player", {26'd0, mv_if.move_x, mv_if.move_y, mv_if.move_player}, 32'd0);
    #3 reset_n = 1'b1;
    tick();

    // Empty board: centre after full line scan.
    launch({9{E}}, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_valid(1, n);
    chk("t1_latency", 32'(n), 32'd9);
    chk("t1_move", {28'd0, mv_if.move_x, mv_if.move_y}, {28'd0, 2'd1, 2'd1});
    chk("t1_player", 32'(mv_if.move_player), 32'd0);
    accept("t1");

    // Own win on row 0.
    launch(brd(A, A, E, E, E, E, E, E, E), 1'b0);
    wait_valid(1, n);
    chk("t2_latency", 32'(n), 32'd2);
    chk("t2_move", {28'd0, mv_if.move_x, mv_if.move_y}, {28'd0, 2'd0, 2'd2});
    accept("t2");

    // Block opponent on column 1.
    launch(brd(E, B, E, E, B, E, E, E, E), 1'b0);
    wait_valid(1, n);
    chk("t3_latency", 32'(n), 32'd9);
    chk("t3_move", {28'd0, mv_if.move_x, mv_if.move_y}, {28'd0, 2'd2, 2'd1});
    chk("t3_player", 32'(mv_if.move_player), 32'd0);
    accept("t3");

    // Full board: single no_move pulse, never a move.
    launch(brd(A, B, A, A, B, B, B, A, A), 1'b0);
    n = 1;
    pulses = 0;
    first_nm = 0;
    saw_valid = 1'b0;
    repeat (24) begin
      tick();
      n++;
      if (no_move === 1'b1) begin
        pulses++;
        if (first_nm == 0) first_nm = n;
      end
      if (mv_if.move_valid !== 1'b0) saw_valid = 1'b1;
    end
    chk("t4_no_move_cycle", 32'(first_nm), 32'd18);
    chk("t4_no_move_pulses", 32'(pulses), 32'd1);
    chk("t4_no_valid", 32'(saw_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // Win on the anti-diagonal for player 1, then stall the accept.
    launch(brd(E, E, B, E, B, E, E, E, E), 1'b1);
    wait_valid(1, n);
    chk("t5_latency", 32'(n), 32'd9);
    sx = 2'd2;
    sy = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold", {25'd0, mv_if.move_valid, busy, mv_if.move_x, mv_if.move_y},
          {25'd0, 1'b1, 1'b1, sx, sy});
      chk("t5_hold_player", 32'(mv_if.move_player), 32'd1);
    end
    accept("t5");

    // Centre held by code 2: falls through to the cell scan, first empty is (0,2).
    launch(brd(A, B, E, E, N, E, E, E, E), 1'b0);
    wait_valid(1, n);
    chk("t7_latency", 32'(n), 32'd12);
    chk("t7_move", {28'd0, mv_if.move_x, mv_if.move_y}, {28'd0, 2'd0, 2'd2});
    accept("t7");

    // Abort during LINES.
    launch({9{E}}, 1'b0);
    tick();
    stop_game = 1'b1;
    tick();
    stop_game = 1'b0;
    chk("t6_stop_busy", 32'(busy), 32'd0);
    chk("t6_stop_valid", 32'(mv_if.move_valid), 32'd0);
    saw_valid = 1'b0;
    repeat (12) begin
      tick();
      if (mv_if.move_valid !== 1'b0 || no_move !== 1'b0) saw_valid = 1'b1;
    end
    chk("t6_stop_quiet", 32'(saw_valid), 32'd0);

    // Start together with stop_game is ignored.
    stop_game = 1'b1;
    launch({9{E}}, 1'b0);
    stop_game = 1'b0;
    chk("t6_start_with_stop", 32'(busy), 32'd0);
    tick();

    // Second start and board change while busy are ignored.
    launch({9{E}}, 1'b0);
    tick();
    tick();
    board_in  = brd(A, B, A, A, B, B, B, A, A);
    my_player = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_valid(4, n);
    chk("t6_busy_start_latency", 32'(n), 32'd9);
    chk("t6_busy_start_move", {26'd0, mv_if.move_x, mv_if.move_y, mv_if.move_player},
        {26'd0, 2'd1, 2'd1, 2'd0});

    // Asynchronous reset while a move is offered.
    #2 reset_n = 1'b0;
    #1;
    chk("t6_reset_valid", 32'(mv_if.move_valid), 32'd0);
    chk("t6_reset_busy", 32'(busy), 32'd0);
    chk("t6_reset_xy", {28'd0, mv_if.move_x, mv_if.move_y}, 32'd0);
    #3 reset_n = 1'b1;
    tick();
    chk("t6_after_reset", {30'd0, mv_if.move_valid, busy}, 32'd0);

    // Ready while nothing is offered does nothing.
    mv_if.move_ready = 1'b1;
    tick();
    mv_if.move_ready = 1'b0;
    chk("t6_idle_ready", {30'd0, mv_if.move_valid, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
